// File: rtl/coreriscv_axi4_prci_arbiter.sv
// Two-client arbiter onto the PRCI TileLink port, with in-order grant return.
// Define PRCI_ARB_FIXED_PRIO_EN to give client 0 fixed priority instead of round-robin.
module coreriscv_axi4_prci_arbiter #(
   parameter int DEPTH = 2,
   parameter int ACQ_W = 111,
   parameter int GNT_W = 75
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             c0_acq_valid,
   output logic             c0_acq_ready,
   input  logic [ACQ_W-1:0] c0_acq_bits,
   output logic             c0_gnt_valid,
   input  logic             c0_gnt_ready,
   input  logic             c1_acq_valid,
   output logic             c1_acq_ready,
   input  logic [ACQ_W-1:0] c1_acq_bits,
   output logic             c1_gnt_valid,
   input  logic             c1_gnt_ready,
   output logic [GNT_W-1:0] gnt_bits,
   output logic             m_acq_valid,
   input  logic             m_acq_ready,
   output logic [ACQ_W-1:0] m_acq_bits,
   input  logic             m_gnt_valid,
   output logic             m_gnt_ready,
   input  logic [GNT_W-1:0] m_gnt_bits,
   output logic             busy,
   output logic             err
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [DEPTH-1:0] owner_q;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [CNT_W-1:0] count;
   logic             lock;
   logic             lock_sel;
   logic             err_q;
   logic             sel;
   logic             rr_pick;
   logic             full;
   logic             empty;
   logic             owner;
   logic             accept;
   logic             pop;

`ifdef PRCI_ARB_FIXED_PRIO_EN
   assign rr_pick = 1'b0;
`else
   logic last_win;
   assign rr_pick = ~last_win;

   always_ff @(posedge clk) begin
      if (reset)
         last_win <= 1'b1;
      else if (accept)
         last_win <= sel;
   end
`endif

   function automatic logic [PTR_W-1:0] inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);
   assign owner = owner_q[rd_ptr];

   // A stalled requester that keeps valid high holds the port
   always_comb begin
      sel = c1_acq_valid;
      if (lock && (lock_sel ? c1_acq_valid : c0_acq_valid))
         sel = lock_sel;
      else if (c0_acq_valid && c1_acq_valid)
         sel = rr_pick;
   end

   assign m_acq_valid  = (c0_acq_valid | c1_acq_valid) & ~full;
   assign m_acq_bits   = sel ? c1_acq_bits : c0_acq_bits;
   assign c0_acq_ready = m_acq_ready & ~full & ~sel;
   assign c1_acq_ready = m_acq_ready & ~full & sel;
   assign accept       = m_acq_valid & m_acq_ready;

   assign c0_gnt_valid = m_gnt_valid & ~empty & ~owner;
   assign c1_gnt_valid = m_gnt_valid & ~empty & owner;
   assign m_gnt_ready  = empty ? 1'b1 : (owner ? c1_gnt_ready : c0_gnt_ready);
   assign gnt_bits     = m_gnt_bits;
   assign pop          = m_gnt_valid & m_gnt_ready & ~empty;

   assign busy = ~empty;
   assign err  = err_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         owner_q  <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         lock     <= 1'b0;
         lock_sel <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         if (accept) begin
            owner_q[wr_ptr] <= sel;
            wr_ptr          <= inc(wr_ptr);
         end
         if (pop)
            rd_ptr <= inc(rd_ptr);
         if (accept && !pop)
            count <= count + CNT_W'(1);
         else if (pop && !accept)
            count <= count - CNT_W'(1);
         lock     <= m_acq_valid & ~m_acq_ready;
         lock_sel <= sel;
         // Grants with nothing outstanding are swallowed and flagged
         if (m_gnt_valid && empty)
            err_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_coreriscv_axi4_prci_arbiter.sv
// Bench for coreriscv_axi4_prci_arbiter: vector table, directed sequences,
// and randomized traffic against a queue-based reference model.
module tb_coreriscv_axi4_prci_arbiter;

   localparam int DEPTH = 2;
   localparam int ACQ_W = 111;
   localparam int GNT_W = 75;
`ifdef PRCI_ARB_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             reset;
   logic             c0_acq_valid, c0_acq_ready, c0_gnt_valid, c0_gnt_ready;
   logic             c1_acq_valid, c1_acq_ready, c1_gnt_valid, c1_gnt_ready;
   logic [ACQ_W-1:0] c0_acq_bits, c1_acq_bits, m_acq_bits;
   logic [GNT_W-1:0] gnt_bits, m_gnt_bits;
   logic             m_acq_valid, m_acq_ready, m_gnt_valid, m_gnt_ready;
   logic             busy, err;

   int tests = 0;
   int fails = 0;

   coreriscv_axi4_prci_arbiter #(.DEPTH(DEPTH), .ACQ_W(ACQ_W), .GNT_W(GNT_W)) dut (
      .clk(clk), .reset(reset),
      .c0_acq_valid(c0_acq_valid), .c0_acq_ready(c0_acq_ready),
      .c0_acq_bits(c0_acq_bits), .c0_gnt_valid(c0_gnt_valid),
      .c0_gnt_ready(c0_gnt_ready),
      .c1_acq_valid(c1_acq_valid), .c1_acq_ready(c1_acq_ready),
      .c1_acq_bits(c1_acq_bits), .c1_gnt_valid(c1_gnt_valid),
      .c1_gnt_ready(c1_gnt_ready),
      .gnt_bits(gnt_bits),
      .m_acq_valid(m_acq_valid), .m_acq_ready(m_acq_ready),
      .m_acq_bits(m_acq_bits),
      .m_gnt_valid(m_gnt_valid), .m_gnt_ready(m_gnt_ready),
      .m_gnt_bits(m_gnt_bits),
      .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   // Reference model: queue of owners plus a few scalar flags
   int q[$];
   bit m_last;
   bit m_lock;
   bit m_lock_who;
   bit m_err;
   bit e_sel, e_mav, e_c0ar, e_c1ar, e_c0gv, e_c1gv, e_mgr;

   task automatic check(input string name, input logic [127:0] act,
                        input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_eval();
      bit full, empty, own;
      full  = (q.size() >= DEPTH);
      empty = (q.size() == 0);
      if (m_lock && (m_lock_who ? c1_acq_valid : c0_acq_valid))
         e_sel = m_lock_who;
      else if (c0_acq_valid && c1_acq_valid)
         e_sel = FIXED ? 1'b0 : !m_last;
      else
         e_sel = c1_acq_valid;
      e_mav  = (c0_acq_valid || c1_acq_valid) && !full;
      e_c0ar = m_acq_ready && !full && (e_sel == 1'b0);
      e_c1ar = m_acq_ready && !full && (e_sel == 1'b1);
      own    = empty ? 1'b0 : q[0][0];
      e_c0gv = m_gnt_valid && !empty && !own;
      e_c1gv = m_gnt_valid && !empty && own;
      e_mgr  = empty ? 1'b1 : (own ? c1_gnt_ready : c0_gnt_ready);
   endtask

   task automatic model_update();
      bit empty;
      model_eval();
      empty = (q.size() == 0);
      if (reset) begin
         q.delete();
         m_last = 1'b1;
         m_lock = 1'b0;
         m_lock_who = 1'b0;
         m_err = 1'b0;
      end else begin
         if (m_gnt_valid && e_mgr && !empty)
            void'(q.pop_front());
         if (e_mav && m_acq_ready) begin
            q.push_back(int'(e_sel));
            m_last = e_sel;
         end
         if (m_gnt_valid && empty)
            m_err = 1'b1;
         m_lock = e_mav && !m_acq_ready;
         m_lock_who = e_sel;
      end
   endtask

   // Called at posedge+1; samples at the falling edge
   task automatic settle();
      #4;
      model_eval();
      check("m_acq_valid", 128'(m_acq_valid), 128'(e_mav));
      if (e_mav)
         check("m_acq_bits", 128'(m_acq_bits),
               128'(e_sel ? c1_acq_bits : c0_acq_bits));
      check("c0_acq_ready", 128'(c0_acq_ready), 128'(e_c0ar));
      check("c1_acq_ready", 128'(c1_acq_ready), 128'(e_c1ar));
      check("c0_gnt_valid", 128'(c0_gnt_valid), 128'(e_c0gv));
      check("c1_gnt_valid", 128'(c1_gnt_valid), 128'(e_c1gv));
      check("m_gnt_ready", 128'(m_gnt_ready), 128'(e_mgr));
      check("gnt_bits", 128'(gnt_bits), 128'(m_gnt_bits));
      check("busy", 128'(busy), 128'(q.size() != 0));
      check("err", 128'(err), 128'(m_err));
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
      #1;
   endtask

   function automatic logic [ACQ_W-1:0] rand_acq();
      logic [127:0] r;
      r = {$urandom(), $urandom(), $urandom(), $urandom()};
      return r[ACQ_W-1:0];
   endfunction

   function automatic logic [GNT_W-1:0] rand_gnt();
      logic [95:0] r;
      r = {$urandom(), $urandom(), $urandom()};
      return r[GNT_W-1:0];
   endfunction

   task automatic idle_inputs();
      c0_acq_valid = 0; c1_acq_valid = 0; m_acq_ready = 0;
      m_gnt_valid = 0; c0_gnt_ready = 0; c1_gnt_ready = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   typedef struct {
      bit c0v, c1v, mar, mgv, c0gr, c1gr;
      bit mav, sel, c0ar, c1ar, c0gv, c1gv, mgr;
   } vec_t;

   vec_t vt[7];
   logic [ACQ_W-1:0] p0, p1;
   bit exp_w[4];

   initial begin
      vt[0] = '{0,0,0,0,0,0, 0,0,0,0,0,0,1};
      vt[1] = '{1,0,1,0,0,0, 1,0,1,0,0,0,1};
      vt[2] = '{0,1,1,0,0,0, 1,1,0,1,0,0,1};
      vt[3] = '{1,1,1,0,0,0, 1,0,1,0,0,0,1};
      vt[4] = '{1,1,0,0,0,0, 1,0,0,0,0,0,1};
      vt[5] = '{0,1,0,0,0,0, 1,1,0,0,0,0,1};
      vt[6] = '{0,0,0,1,0,0, 0,0,0,0,0,0,1};

      idle_inputs();
      c0_acq_bits = '0; c1_acq_bits = '0; m_gnt_bits = '0;
      reset = 1'b1;
      q.delete(); m_last = 1; m_lock = 0; m_lock_who = 0; m_err = 0;
      @(posedge clk); #1;
      do_reset();

      // Reset state
      #4;
      check("rst_m_acq_valid", 128'(m_acq_valid), 128'(0));
      check("rst_c0_acq_ready", 128'(c0_acq_ready), 128'(0));
      check("rst_c1_acq_ready", 128'(c1_acq_ready), 128'(0));
      check("rst_gnt_valid", 128'({c0_gnt_valid, c1_gnt_valid}), 128'(0));
      check("rst_busy", 128'(busy), 128'(0));
      check("rst_err", 128'(err), 128'(0));
      #6;

      // Single-cycle vectors, each from the reset state
      foreach (vt[i]) begin
         p0 = rand_acq(); p1 = rand_acq();
         c0_acq_bits = p0; c1_acq_bits = p1;
         c0_acq_valid = vt[i].c0v; c1_acq_valid = vt[i].c1v;
         m_acq_ready = vt[i].mar; m_gnt_valid = vt[i].mgv;
         c0_gnt_ready = vt[i].c0gr; c1_gnt_ready = vt[i].c1gr;
         m_gnt_bits = rand_gnt();
         settle();
         check($sformatf("vec%0d_mav", i), 128'(m_acq_valid), 128'(vt[i].mav));
         if (vt[i].mav)
            check($sformatf("vec%0d_bits", i), 128'(m_acq_bits),
                  128'(vt[i].sel ? p1 : p0));
         check($sformatf("vec%0d_c0ar", i), 128'(c0_acq_ready), 128'(vt[i].c0ar));
         check($sformatf("vec%0d_c1ar", i), 128'(c1_acq_ready), 128'(vt[i].c1ar));
         check($sformatf("vec%0d_c0gv", i), 128'(c0_gnt_valid), 128'(vt[i].c0gv));
         check($sformatf("vec%0d_c1gv", i), 128'(c1_gnt_valid), 128'(vt[i].c1gv));
         check($sformatf("vec%0d_mgr", i), 128'(m_gnt_ready), 128'(vt[i].mgr));
         reset = 1'b1;
         tick();
         reset = 1'b0;
         idle_inputs();
      end

      // Basic get from c0 and its grant
      do_reset();
      p0 = rand_acq();
      p0[25:0] = 26'h2000;
      c0_acq_bits = p0; c0_acq_valid = 1; m_acq_ready = 1;
      settle();
      check("s1_m_acq_bits", 128'(m_acq_bits), 128'(p0));
      check("s1_c0_acq_ready", 128'(c0_acq_ready), 128'(1));
      tick();
      idle_inputs();
      m_gnt_bits = '0;
      m_gnt_bits[74:11] = 64'h5;
      m_gnt_valid = 1; c0_gnt_ready = 1;
      settle();
      check("s1_busy_before", 128'(busy), 128'(1));
      check("s1_c0_gnt_valid", 128'(c0_gnt_valid), 128'(1));
      check("s1_c1_gnt_valid", 128'(c1_gnt_valid), 128'(0));
      check("s1_gnt_data", 128'(gnt_bits[74:11]), 128'(64'h5));
      tick();
      idle_inputs();
      settle();
      check("s1_busy_after", 128'(busy), 128'(0));
      tick();

      // Both requesting every cycle
      do_reset();
      exp_w = FIXED ? '{0, 0, 0, 0} : '{0, 1, 0, 1};
      for (int i = 0; i < 4; i++) begin
         c0_acq_valid = 1; c1_acq_valid = 1; m_acq_ready = 1;
         c0_acq_bits = rand_acq(); c1_acq_bits = rand_acq();
         c0_gnt_ready = 1; c1_gnt_ready = 1;
         m_gnt_valid = (q.size() != 0);
         m_gnt_bits = rand_gnt();
         settle();
         check($sformatf("s2_winner%0d", i), 128'(c1_acq_ready), 128'(exp_w[i]));
         tick();
      end
      idle_inputs();
      m_gnt_valid = 1; c0_gnt_ready = 1; c1_gnt_ready = 1;
      settle();
      tick();
      idle_inputs();

      // Owner FIFO fills, then frees one slot
      do_reset();
      c1_acq_valid = 1; m_acq_ready = 1; c1_acq_bits = rand_acq();
      settle();
      check("s3_acc1", 128'(c1_acq_ready), 128'(1));
      tick();
      settle();
      check("s3_acc2", 128'(c1_acq_ready), 128'(1));
      tick();
      settle();
      check("s3_full_stall", 128'(c1_acq_ready), 128'(0));
      tick();
      m_gnt_valid = 1; c1_gnt_ready = 1; m_gnt_bits = rand_gnt();
      settle();
      check("s3_pop_gnt", 128'(c1_gnt_valid), 128'(1));
      check("s3_pop_blocked", 128'(c1_acq_ready), 128'(0));
      tick();
      m_gnt_valid = 0;
      settle();
      check("s3_after_pop", 128'(c1_acq_ready), 128'(1));
      tick();
      idle_inputs();
      m_gnt_valid = 1; c1_gnt_ready = 1;
      for (int i = 0; i < 2; i++) begin
         settle();
         tick();
      end
      idle_inputs();
      settle();
      check("s3_drained", 128'(busy), 128'(0));
      tick();

      // Accept and pop in the same cycle
      do_reset();
      c0_acq_valid = 1; m_acq_ready = 1; c0_acq_bits = rand_acq();
      settle();
      tick();
      idle_inputs();
      c1_acq_valid = 1; m_acq_ready = 1; c1_acq_bits = rand_acq();
      m_gnt_valid = 1; c0_gnt_ready = 1;
      settle();
      check("s4_c0_gnt", 128'(c0_gnt_valid), 128'(1));
      check("s4_c1_acc", 128'(c1_acq_ready), 128'(1));
      tick();
      idle_inputs();
      m_gnt_valid = 1; c1_gnt_ready = 1;
      settle();
      check("s4_busy", 128'(busy), 128'(1));
      check("s4_c1_gnt", 128'(c1_gnt_valid), 128'(1));
      check("s4_c0_gnt_off", 128'(c0_gnt_valid), 128'(0));
      tick();
      idle_inputs();
      settle();
      check("s4_empty", 128'(busy), 128'(0));
      tick();

      // Stray grant with nothing outstanding
      do_reset();
      m_gnt_valid = 1; m_gnt_bits = rand_gnt();
      settle();
      check("s5_mgr", 128'(m_gnt_ready), 128'(1));
      check("s5_no_gv", 128'({c0_gnt_valid, c1_gnt_valid}), 128'(0));
      tick();
      idle_inputs();
      for (int i = 0; i < 3; i++) begin
         settle();
         check($sformatf("s5_err_sticky%0d", i), 128'(err), 128'(1));
         tick();
      end

      // Stall lock: c0 keeps the port while c1 joins
      do_reset();
      c0_acq_valid = 1; m_acq_ready = 1; c0_acq_bits = rand_acq();
      settle();
      tick();
      idle_inputs();
      m_gnt_valid = 1; c0_gnt_ready = 1;
      settle();
      tick();
      idle_inputs();
      p0 = rand_acq(); p1 = rand_acq();
      c0_acq_bits = p0; c1_acq_bits = p1; c0_acq_valid = 1;
      for (int i = 0; i < 5; i++) begin
         if (i >= 1) c1_acq_valid = 1;
         settle();
         check($sformatf("s6_hold%0d", i), 128'(m_acq_bits), 128'(p0));
         tick();
      end
      m_acq_ready = 1;
      settle();
      check("s6_c0_acc", 128'(c0_acq_ready), 128'(1));
      check("s6_c1_wait", 128'(c1_acq_ready), 128'(0));
      tick();
      idle_inputs();

      // Randomized traffic
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         reset = ($urandom_range(0, 299) == 0);
         c0_acq_valid = ($urandom_range(0, 2) != 0);
         c1_acq_valid = ($urandom_range(0, 2) != 0);
         c0_acq_bits = rand_acq();
         c1_acq_bits = rand_acq();
         m_acq_ready = ($urandom_range(0, 3) != 0);
         m_gnt_valid = (q.size() != 0) ? ($urandom_range(0, 1) == 1)
                                       : ($urandom_range(0, 30) == 0);
         c0_gnt_ready = ($urandom_range(0, 3) != 0);
         c1_gnt_ready = ($urandom_range(0, 3) != 0);
         m_gnt_bits = rand_gnt();
         settle();
         tick();
      end
      reset = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
